// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - valid/ready word handshake into the UART transmitter
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with busy/done status
module uart_tx_cfg #(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_tx_cfg_if.slave  up,
    output logic          tx_out,
    output logic          tx_busy,
    output logic          tx_done
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = 4;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 out_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    logic [DATA_BITS-1:0] shift_d;
    logic                 parity_d;
    logic                 baud_wrap;

    assign shift_d   = shift_q >> 1;
    assign parity_d  = (PARITY == 1) ? ~^up.tx_data : ^up.tx_data;
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            out_q    <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                baud_q <= baud_wrap ? '0 : baud_q + BAUD_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    // Start bit goes out on the accept edge itself
                    if (up.tx_valid) begin
                        shift_q  <= up.tx_data;
                        parity_q <= parity_d;
                        state_q  <= S_START;
                        out_q    <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_wrap) begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        out_q   <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (baud_wrap) begin
                        if (bit_q == DATA_LAST) begin
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                out_q   <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                bit_q   <= '0;
                                out_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            shift_q <= shift_d;
                            out_q   <= shift_d[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_wrap) begin
                        state_q <= S_STOP;
                        bit_q   <= '0;
                        out_q   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_wrap) begin
                        if (bit_q == STOP_LAST) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            out_q   <= 1'b1;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    out_q   <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign up.tx_ready = ready_q;
    assign tx_out      = out_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter: serialises one word per frame as start bit, DATA_BITS data bits LSB-first, optional parity bit, then 1 or 2 stop bits.
- Upstream interface is a valid/ready handshake; the accepted word is captured internally, so the source may change tx_data after acceptance.
- Adds frame-complete and busy status for debug/host reporting logic in the DDR2 test system.

Parameters:
- CLK_DIV, 5208: clock cycles per bit period. Legal range ≥ 2. Baud counter width is $clog2(CLK_DIV).
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- tx_data  input  DATA_BITS  word to send; sampled only on the accept cycle.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  block can accept a word.
- tx_out  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values (reset_n low at a clock edge):
  - state = IDLE
  - tx_out = 1, tx_ready = 1, tx_busy = 0, tx_done = 0
  - baud counter = 0, bit counter = 0, shift register = 0
- Reset mid-frame aborts the frame immediately: tx_out returns high on the next edge and no tx_done is generated.
- All outputs are registered.
- Accept: when state = IDLE and tx_valid = 1 at a clock edge:
  - tx_data is latched into the shift register.
  - Parity is computed from the latched data: odd = ~^data, even = ^data.
  - state → START, tx_ready → 0, tx_busy → 1.
  - tx_valid while not in IDLE is ignored; no data is captured.
- FSM states:
  - IDLE: tx_out = 1.
  - START: tx_out = 0 for CLK_DIV cycles.
  - DATA: shift register bit 0 on tx_out, shift right each bit period; DATA_BITS periods.
  - PARITY (present only if PARITY ≠ 0): parity bit for one period.
  - STOP: tx_out = 1 for STOP_BITS periods.
- Bit timing:
  - The baud counter runs 0..CLK_DIV-1 in every non-IDLE state.
  - A bit period ends when the counter = CLK_DIV-1. The counter then wraps to 0, and the state or bit counter advances.
  - The bit counter clears on entry to DATA and on entry to STOP.
- Latency: tx_out falls on the clock edge that accepts the word. START lasts exactly CLK_DIV cycles.
- Frame completion: at the end of the last stop period:
  - state → IDLE, tx_ready → 1, tx_busy → 0.
  - tx_done = 1 for exactly that one following cycle.
- Back-to-back frames: a word presented during the tx_done cycle is accepted on that edge, so the line stays high for exactly 1 extra cycle.
  - Minimum frame period = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV + 1 cycles.
- Unused upper tx_data bits: none; the width equals DATA_BITS exactly.

Test Plan:
1. CLK_DIV=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 → tx_out is 0 (4 clk), then 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk). tx_done pulses 40 cycles after accept; tx_ready is low for 40 cycles.
2. PARITY=2 (even), send 0x07 → parity bit 1. PARITY=1 (odd), send 0x07 → parity bit 0. Frame length is 44 cycles at CLK_DIV=4.
3. DATA_BITS=5, STOP_BITS=2, send 5'h1F → frame = start, five 1s, two stop periods, 32 cycles total. Bits of tx_data above bit 4 do not exist.
4. Hold tx_valid high with tx_data changing every cycle → exactly one word is captured per frame. The captured value is tx_data on the accept edge. Consecutive start bits are separated by frame length + 1 cycles.
5. Assert reset_n low during the third data bit → next edge gives tx_out=1, tx_busy=0, tx_ready=1, and no tx_done. A subsequent send of 0x3C transmits correctly.
6. Default parameters (CLK_DIV=5208), send 0x55 → each bit period is 5208 cycles ±0. tx_done fires 52080 cycles after accept.
